// File: rtl/drv_pwr_seq_if.sv
// Drive power-sequencer signal bundle: board-side inputs and per-drive
// power outputs, grouped so the sequencer and its environment share one port.
interface drv_pwr_seq_if #(
  parameter int NUM_DRV = 24
);
  logic               SEQ_EN;
  logic [NUM_DRV-1:0] DRV_PRSNT_N;
  logic [NUM_DRV-1:0] DRV_PG;
  logic [NUM_DRV-1:0] FAULT_CLR;
  logic [NUM_DRV-1:0] DRV_PWREN;
  logic [NUM_DRV-1:0] DRV_PWROK;
  logic [NUM_DRV-1:0] DRV_FAULT;

  // Board / hot-swap side: drives presence, power-good, enable and fault clear.
  modport master (
    output SEQ_EN, DRV_PRSNT_N, DRV_PG, FAULT_CLR,
    input  DRV_PWREN, DRV_PWROK, DRV_FAULT
  );

  // Sequencer side.
  modport slave (
    input  SEQ_EN, DRV_PRSNT_N, DRV_PG, FAULT_CLR,
    output DRV_PWREN, DRV_PWROK, DRV_FAULT
  );
endinterface

// File: rtl/drv_pwr_seq.sv
// Per-drive power sequencer: presence debounce, staggered power-enable
// arbitration, power-good timeout check and DRV_PWROK generation.
module drv_pwr_seq #(
  parameter int NUM_DRV        = 24,
  parameter int DEBOUNCE_CYC   = 16,
  parameter int STAGGER_CYC    = 1000,
  parameter int PG_TIMEOUT_CYC = 5000
) (
  input logic          SYSCLK,
  input logic          RESET_N,
  drv_pwr_seq_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int ST_W = $clog2(STAGGER_CYC + 1);
  localparam int TO_W = $clog2(PG_TIMEOUT_CYC + 1);

  // Last count value before the threshold: reaching it again means the
  // threshold is hit on this edge.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(PG_TIMEOUT_CYC - 1);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STAGGER_CYC);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAIT,
    ST_RAMP,
    ST_ON,
    ST_FAULT
  } state_t;

  logic [NUM_DRV-1:0] prs_s1_q, prs_s2_q;
  logic [NUM_DRV-1:0] pg_s1_q, pg_s2_q;
  logic [NUM_DRV-1:0] req;
  logic [NUM_DRV-1:0] gnt;
  logic [ST_W-1:0]    stg_q, stg_d;
  logic               stg_ready;

  // Two-flop synchronizers; presence resets to "absent", power-good to low.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prs_s1_q <= '1;
      prs_s2_q <= '1;
      pg_s1_q  <= '0;
      pg_s2_q  <= '0;
    end else begin
      prs_s1_q <= bus.DRV_PRSNT_N;
      prs_s2_q <= prs_s1_q;
      pg_s1_q  <= bus.DRV_PG;
      pg_s2_q  <= pg_s1_q;
    end
  end

  // Stagger arbiter: lowest-index requester wins when the timer is ready.
  // Ready is flagged while the timer is at 1 or 0 so that the next grant
  // lands exactly STAGGER_CYC edges after the previous one.
  always_comb begin
    stg_ready = (stg_q <= ST_W'(1));
    gnt       = stg_ready ? (req & (~req + NUM_DRV'(1))) : '0;
    stg_d     = (stg_q != '0) ? (stg_q - ST_W'(1)) : '0;
    if (gnt != '0) begin
      stg_d = ST_LOAD;
    end
  end

  // Stagger timer register; reset leaves it expired.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stg_q <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  for (genvar gi = 0; gi < NUM_DRV; gi++) begin : g_drv
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            prs_deb_q, prs_deb_d;
    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            pwren_q, pwren_d;
    logic            pwrok_q, pwrok_d;
    logic            fault_q, fault_d;
    logic            qual;

    // A drive may be powered only while debounced-present and globally enabled.
    assign qual    = ~prs_deb_q & bus.SEQ_EN;
    assign req[gi] = (state_q == ST_WAIT) & qual;

    assign bus.DRV_PWREN[gi] = pwren_q;
    assign bus.DRV_PWROK[gi] = pwrok_q;
    assign bus.DRV_FAULT[gi] = fault_q;

    // Debounce: count consecutive cycles the synchronized level disagrees
    // with the accepted level; accept it when the count hits DEBOUNCE_CYC.
    always_comb begin
      db_cnt_d  = '0;
      prs_deb_d = prs_deb_q;
      if (prs_s2_q[gi] != prs_deb_q) begin
        if (db_cnt_q >= DB_LAST) begin
          prs_deb_d = prs_s2_q[gi];
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
    end

    // Drive FSM next state; outputs are decoded from the next state so they
    // are registered and valid from the first cycle of each state.
    always_comb begin
      state_d  = state_q;
      to_cnt_d = to_cnt_q;
      case (state_q)
        ST_OFF: begin
          if (qual) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (!qual) begin
            state_d = ST_OFF;
          end else if (gnt[gi]) begin
            state_d  = ST_RAMP;
            to_cnt_d = '0;
          end
        end
        ST_RAMP: begin
          // Removal beats power-good, power-good beats timeout.
          if (!qual) begin
            state_d = ST_OFF;
          end else if (pg_s2_q[gi]) begin
            state_d = ST_ON;
          end else if (to_cnt_q >= TO_LAST) begin
            state_d = ST_FAULT;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        ST_ON: begin
          if (!qual) begin
            state_d = ST_OFF;
          end else if (!pg_s2_q[gi]) begin
            state_d = ST_FAULT;
          end
        end
        ST_FAULT: begin
          // Sticky: only an explicit clear leaves, presence/enable ignored.
          if (bus.FAULT_CLR[gi]) state_d = ST_OFF;
        end
        default: state_d = ST_OFF;
      endcase
      pwren_d = (state_d == ST_RAMP) || (state_d == ST_ON);
      pwrok_d = (state_d == ST_ON);
      fault_d = (state_d == ST_FAULT);
    end

    // Per-drive state, counters and registered outputs.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
        db_cnt_q  <= '0;
        prs_deb_q <= 1'b1;
        state_q   <= ST_OFF;
        to_cnt_q  <= '0;
        pwren_q   <= 1'b0;
        pwrok_q   <= 1'b0;
        fault_q   <= 1'b0;
      end else begin
        db_cnt_q  <= db_cnt_d;
        prs_deb_q <= prs_deb_d;
        state_q   <= state_d;
        to_cnt_q  <= to_cnt_d;
        pwren_q   <= pwren_d;
        pwrok_q   <= pwrok_d;
        fault_q   <= fault_d;
      end
    end
  end

endmodule

// File: tb/tb_drv_pwr_seq.sv
// Directed bench for drv_pwr_seq: a timestamp-based behavioural model checked
// every cycle, plus hand-computed latency and spacing expectations.
module tb_drv_pwr_seq;
  localparam int N   = 24;
  localparam int DB  = 16;
  localparam int STG = 1000;
  localparam int TO  = 5000;

  localparam int P_OFF   = 0;
  localparam int P_WAIT  = 1;
  localparam int P_RAMP  = 2;
  localparam int P_ON    = 3;
  localparam int P_FAULT = 4;

  logic SYSCLK  = 1'b0;
  logic RESET_N = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  drv_pwr_seq_if #(.NUM_DRV(N)) bus ();

  drv_pwr_seq #(
    .NUM_DRV       (N),
    .DEBOUNCE_CYC  (DB),
    .STAGGER_CYC   (STG),
    .PG_TIMEOUT_CYC(TO)
  ) dut (
    .SYSCLK (SYSCLK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge SYSCLK) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  int       now;
  int       last_gnt;
  int       winner;
  bit       qual;
  int       phase     [N];
  int       ramp_start[N];
  int       run       [N];
  bit       acc_absent[N];
  bit       ps1[N], ps2[N], pg1[N], pg2[N];
  logic [N-1:0] exp_en, exp_ok, exp_flt;

  always @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      now      = 0;
      last_gnt = -STG;
      for (int i = 0; i < N; i++) begin
        phase[i] = P_OFF; ramp_start[i] = 0; run[i] = 0; acc_absent[i] = 1'b1;
        ps1[i] = 1'b1; ps2[i] = 1'b1; pg1[i] = 1'b0; pg2[i] = 1'b0;
      end
      exp_en = '0; exp_ok = '0; exp_flt = '0;
    end else begin
      now++;
      winner = -1;
      // one grant at most, STG edges apart, to the lowest qualified waiter
      if (now - last_gnt >= STG) begin
        for (int i = 0; i < N; i++)
          if (winner < 0 && phase[i] == P_WAIT && !acc_absent[i] && bus.SEQ_EN) winner = i;
      end
      if (winner >= 0) last_gnt = now;
      for (int i = 0; i < N; i++) begin
        qual = !acc_absent[i] && bus.SEQ_EN;
        case (phase[i])
          P_OFF:   if (qual) phase[i] = P_WAIT;
          P_WAIT:  if (!qual) phase[i] = P_OFF;
                   else if (i == winner) begin phase[i] = P_RAMP; ramp_start[i] = now; end
          P_RAMP:  if (!qual) phase[i] = P_OFF;
                   else if (pg2[i]) phase[i] = P_ON;
                   else if (now - ramp_start[i] >= TO) phase[i] = P_FAULT;
          P_ON:    if (!qual) phase[i] = P_OFF;
                   else if (!pg2[i]) phase[i] = P_FAULT;
          default: if (bus.FAULT_CLR[i]) phase[i] = P_OFF;
        endcase
        // accept a synchronized level after DB consecutive disagreeing edges
        if (ps2[i] != acc_absent[i]) begin
          run[i]++;
          if (run[i] == DB) begin acc_absent[i] = ps2[i]; run[i] = 0; end
        end else begin
          run[i] = 0;
        end
        ps2[i] = ps1[i]; ps1[i] = bus.DRV_PRSNT_N[i];
        pg2[i] = pg1[i]; pg1[i] = bus.DRV_PG[i];
        exp_en[i]  = (phase[i] == P_RAMP) || (phase[i] == P_ON);
        exp_ok[i]  = (phase[i] == P_ON);
        exp_flt[i] = (phase[i] == P_FAULT);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge SYSCLK) begin
    if (RESET_N) begin
      n_cmp++;
      if (bus.DRV_PWREN !== exp_en) begin
        n_fail++;
        $display("FAIL model_pwren cyc=%0d got=%h expected=%h", cyc, bus.DRV_PWREN, exp_en);
      end
      n_cmp++;
      if (bus.DRV_PWROK !== exp_ok) begin
        n_fail++;
        $display("FAIL model_pwrok cyc=%0d got=%h expected=%h", cyc, bus.DRV_PWROK, exp_ok);
      end
      n_cmp++;
      if (bus.DRV_FAULT !== exp_flt) begin
        n_fail++;
        $display("FAIL model_fault cyc=%0d got=%h expected=%h", cyc, bus.DRV_FAULT, exp_flt);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge SYSCLK);
      #1;
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
    else $display("check %s = %b", name, act);
  endtask

  task automatic chk_v(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
    else $display("check %s = %h", name, act);
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
    else $display("check %s = %0d", name, act);
  endtask

  // Bounded wait for a PWREN bit to rise; returns the edge count it rose on.
  task automatic wait_rise(input int idx, input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      if (bus.DRV_PWREN[idx]) begin
        at = cyc;
        break;
      end
      tick();
    end
    n_cmp++;
    if (at < 0) begin
      n_fail++;
      $display("FAIL wait_pwren%0d: no rise within %0d cycles, expected a rise", idx, limit);
    end
    else $display("pwren[%0d] rose at cycle %0d", idx, at);
  endtask

  int t0, r0, r5, r23, r3, r3b, r7, r12, r0b, clr_edge;
  logic [N-1:0] on_set;

  initial begin
    bus.SEQ_EN      = 1'b0;
    bus.DRV_PRSNT_N = '1;
    bus.DRV_PG      = '0;
    bus.FAULT_CLR   = '0;
    RESET_N         = 1'b0;
    tick(3);
    chk_v("reset_pwren", bus.DRV_PWREN, '0);
    chk_v("reset_pwrok", bus.DRV_PWROK, '0);
    chk_v("reset_fault", bus.DRV_FAULT, '0);
    RESET_N    = 1'b1;
    bus.SEQ_EN = 1'b1;
    tick(2);

    // single insertion on 0 together with 5 and 23 (stagger)
    t0 = cyc;
    bus.DRV_PRSNT_N[0]  = 1'b0;
    bus.DRV_PRSNT_N[5]  = 1'b0;
    bus.DRV_PRSNT_N[23] = 1'b0;
    tick(19);
    chk_b("ins0_pwren_at_19", bus.DRV_PWREN[0], 1'b0);
    tick(1);
    chk_b("ins0_pwren_at_20", bus.DRV_PWREN[0], 1'b1);
    r0 = cyc;
    chk_b("ins5_not_yet", bus.DRV_PWREN[5], 1'b0);
    tick(10);
    bus.DRV_PG[0] = 1'b1;
    tick(2);
    chk_b("pg0_pwrok_at_2", bus.DRV_PWROK[0], 1'b0);
    tick(1);
    chk_b("pg0_pwrok_at_3", bus.DRV_PWROK[0], 1'b1);
    wait_rise(5, 1100, r5);
    chk_i("stagger_0_to_5", r5 - r0, STG);
    bus.DRV_PG[5] = 1'b1;
    wait_rise(23, 1100, r23);
    chk_i("stagger_5_to_23", r23 - r5, STG);
    bus.DRV_PG[23] = 1'b1;

    // timeout on drive 3; clear pulse also hits ON drive 0 (must be ignored)
    tick(5);
    bus.DRV_PRSNT_N[3] = 1'b0;
    wait_rise(3, 1100, r3);
    tick(TO - 1);
    chk_b("to3_pwren_last_ramp", bus.DRV_PWREN[3], 1'b1);
    chk_b("to3_fault_not_yet", bus.DRV_FAULT[3], 1'b0);
    tick(1);
    chk_b("to3_pwren_dropped", bus.DRV_PWREN[3], 1'b0);
    chk_b("to3_fault_set", bus.DRV_FAULT[3], 1'b1);
    tick(5);
    bus.FAULT_CLR[3] = 1'b1;
    bus.FAULT_CLR[0] = 1'b1;
    tick(1);
    bus.FAULT_CLR = '0;
    clr_edge = cyc;
    chk_b("clr3_fault_cleared", bus.DRV_FAULT[3], 1'b0);
    chk_b("clr0_ignored_pwrok", bus.DRV_PWROK[0], 1'b1);
    wait_rise(3, 10, r3b);
    chk_i("reseq3_latency", r3b - clr_edge, 2);
    bus.DRV_PG[3] = 1'b1;

    // brownout on 7; drive 12 inserted alongside with PG already good
    bus.DRV_PG[12]      = 1'b1;
    bus.DRV_PRSNT_N[7]  = 1'b0;
    bus.DRV_PRSNT_N[12] = 1'b0;
    wait_rise(7, 1100, r7);
    bus.DRV_PG[7] = 1'b1;
    tick(3);
    chk_b("bo7_pwrok_on", bus.DRV_PWROK[7], 1'b1);
    bus.DRV_PG[7] = 1'b0;
    tick(2);
    chk_b("bo7_pwrok_before_sync", bus.DRV_PWROK[7], 1'b1);
    tick(1);
    chk_b("bo7_fault", bus.DRV_FAULT[7], 1'b1);
    chk_b("bo7_pwrok_low", bus.DRV_PWROK[7], 1'b0);
    chk_b("bo7_pwren_low", bus.DRV_PWREN[7], 1'b0);
    wait_rise(12, 1100, r12);
    chk_i("stagger_7_to_12", r12 - r7, STG);
    tick(1);
    chk_b("pg12_preset_on", bus.DRV_PWROK[12], 1'b1);

    // 15-cycle presence glitches: removal glitch on ON drive 0, insertion on 10
    bus.DRV_PRSNT_N[0]  = 1'b1;
    bus.DRV_PRSNT_N[10] = 1'b0;
    tick(DB - 1);
    bus.DRV_PRSNT_N[0]  = 1'b0;
    bus.DRV_PRSNT_N[10] = 1'b1;
    tick(30);
    chk_b("glitch0_still_on", bus.DRV_PWROK[0], 1'b1);
    chk_b("glitch10_still_off", bus.DRV_PWREN[10], 1'b0);

    // sustained removal of ON drive 5
    bus.DRV_PRSNT_N[5] = 1'b1;
    tick(18);
    chk_b("rm5_pwren_at_18", bus.DRV_PWREN[5], 1'b1);
    tick(1);
    chk_b("rm5_pwren_at_19", bus.DRV_PWREN[5], 1'b0);
    chk_b("rm5_pwrok_low", bus.DRV_PWROK[5], 1'b0);
    chk_b("rm5_no_fault", bus.DRV_FAULT[5], 1'b0);

    // SEQ_EN drop with four drives ON; fault on 7 retained
    on_set = '0;
    on_set[0] = 1'b1; on_set[3] = 1'b1; on_set[12] = 1'b1; on_set[23] = 1'b1;
    chk_v("four_on", bus.DRV_PWROK, on_set);
    bus.SEQ_EN = 1'b0;
    tick(1);
    chk_v("seqen_pwren_off", bus.DRV_PWREN, '0);
    chk_v("seqen_pwrok_off", bus.DRV_PWROK, '0);
    chk_v("seqen_fault_kept", bus.DRV_FAULT, N'(1) << 7);

    // asynchronous reset in the middle of drive 0's ramp
    bus.DRV_PG = '0;
    tick(3);
    bus.SEQ_EN = 1'b1;
    wait_rise(0, 1100, r0b);
    tick(5);
    chk_b("mid_ramp_pwren0", bus.DRV_PWREN[0], 1'b1);
    RESET_N = 1'b0;
    #1;
    chk_v("async_rst_pwren", bus.DRV_PWREN, '0);
    chk_v("async_rst_pwrok", bus.DRV_PWROK, '0);
    chk_v("async_rst_fault", bus.DRV_FAULT, '0);
    tick(3);
    RESET_N = 1'b1;
    tick(10);
    chk_v("post_rst_pwren", bus.DRV_PWREN, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
